// File: rtl/pmem_multi_arbiter_pkg.sv
// Shared types for the multi-requester pmem arbiter: FSM states,
// grant policy encodings and the transaction type bit.
package pmem_arb_types;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_READ   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  localparam int POL_FIXED = 0;
  localparam int POL_RR    = 1;

  localparam logic TYPE_READ  = 1'b0;
  localparam logic TYPE_WRITE = 1'b1;

endpackage

// File: rtl/pmem_multi_arbiter_picker.sv
// Combinational grant selection. Fixed policy picks the lowest valid index.
// Round robin picks the lowest valid index at or above the pointer, falling
// back to the lowest valid index overall, which is the modulo wrap.
module arb_picker
  import pmem_arb_types::*;
#(
  parameter int NUM_REQ = 3,
  parameter int POLICY  = POL_RR,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               found_o
);

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] hi_valid;
  logic [NUM_REQ-1:0] pick_vec;

  // Requesters whose index is at or above the round-robin pointer
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign hi_mask[gi] = (IDX_W'(gi) >= ptr_i);
  end

  assign hi_valid = valid_i & hi_mask;
  assign found_o  = |valid_i;

  // Lowest set bit of the candidate vector is the winner
  always_comb begin
    pick_vec = valid_i;
    if (POLICY == POL_RR && (|hi_valid)) begin
      pick_vec = hi_valid;
    end
    grant_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (pick_vec[k]) begin
        grant_o = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/pmem_multi_arbiter.sv
// Arbitrates NUM_REQ line-granular requesters onto a single pmem port with
// one transaction outstanding. Optional read coalescing answers every other
// pending read to the same line when a read completes.
module pmem_multi_arbiter
  import pmem_arb_types::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 256,
  parameter int POLICY   = POL_RR,
  parameter int COALESCE = 1,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LINE_W-1:0] req_wdata,
  output logic [LINE_W-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]        req_resp,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      pmem_read,
  output logic                      pmem_write,
  output logic [ADDR_W-1:0]         pmem_address,
  output logic [LINE_W-1:0]         pmem_wdata,
  input  logic                      pmem_resp,
  input  logic [LINE_W-1:0]         pmem_rdata
);

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   grant_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LINE_W-1:0]  wdata_q;
  logic               type_q;
  logic [LINE_W-1:0]  rdata_q;
  logic               pmem_read_q;
  logic               pmem_write_q;

  logic [ADDR_W-1:0]  addr_slice  [NUM_REQ];
  logic [LINE_W-1:0]  wdata_slice [NUM_REQ];
  logic [NUM_REQ-1:0] owner_hot;
  logic [NUM_REQ-1:0] coal_hit;
  logic [NUM_REQ-1:0] valid;
  logic [IDX_W-1:0]   pick_grant;
  logic               pick_found;
  logic [IDX_W-1:0]   ptr_d;
  logic               owner_writes;

  // Unpack per-requester slices and the owner/coalesce match vectors
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign addr_slice[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_slice[gi] = req_wdata[gi*LINE_W +: LINE_W];
    assign owner_hot[gi]   = (grant_q == IDX_W'(gi));
    // Reads-only requesters on the same line as the owner, excluding the owner
    assign coal_hit[gi]    = req_read[gi] & ~req_write[gi] &
                             (addr_slice[gi] == addr_q) & ~owner_hot[gi];
  end

  assign valid        = req_read | req_write;
  // A requester raising both strobes is served as a write
  assign owner_writes = |(req_write & owner_hot);
  assign ptr_d        = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  arb_picker #(
    .NUM_REQ (NUM_REQ),
    .POLICY  (POLICY),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid_i (valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .found_o (pick_found)
  );

  // Transaction sequencer: arbitrate, latch the owner's request, run pmem, respond
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      type_q       <= TYPE_READ;
      rdata_q      <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            grant_q <= pick_grant;
            state_q <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          addr_q <= addr_slice[grant_q];
          ptr_q  <= ptr_d;
          if (owner_writes) begin
            wdata_q      <= wdata_slice[grant_q];
            type_q       <= TYPE_WRITE;
            pmem_write_q <= 1'b1;
            state_q      <= ST_WRITE;
          end else begin
            type_q      <= TYPE_READ;
            pmem_read_q <= 1'b1;
            state_q     <= ST_READ;
          end
        end
        ST_READ: begin
          if (pmem_resp) begin
            rdata_q     <= pmem_rdata;
            pmem_read_q <= 1'b0;
            state_q     <= ST_FINISH;
          end
        end
        ST_WRITE: begin
          if (pmem_resp) begin
            pmem_write_q <= 1'b0;
            state_q      <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Completion pulses: owner always, plus coalesced readers on a read
  always_comb begin
    req_resp = '0;
    if (state_q == ST_FINISH) begin
      req_resp = owner_hot;
      if (COALESCE != 0 && type_q == TYPE_READ) begin
        req_resp = owner_hot | coal_hit;
      end
    end
  end

  assign req_rdata    = rdata_q;
  assign grant_id     = grant_q;
  assign busy         = (state_q != ST_IDLE);
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

endmodule

// File: tb/tb_pmem_multi_arbiter.sv
// Directed bench for pmem_multi_arbiter. Three instances share clock/reset:
// [0] round robin + coalescing, [1] fixed priority, [2] round robin without
// coalescing. Each has its own request inputs and a simple pmem responder.
module tb_pmem_multi_arbiter;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int NI = 3;

  logic clk;
  logic reset;

  logic [NR-1:0]    rd_v     [NI];
  logic [NR-1:0]    wr_v     [NI];
  logic [NR*AW-1:0] addr_v   [NI];
  logic [NR*LW-1:0] wdata_v  [NI];
  logic [LW-1:0]    rdata_w  [NI];
  logic [NR-1:0]    resp_w   [NI];
  logic [1:0]       gid_w    [NI];
  logic             busy_w   [NI];
  logic             prd_w    [NI];
  logic             pwr_w    [NI];
  logic [AW-1:0]    paddr_w  [NI];
  logic [LW-1:0]    pwdata_w [NI];
  logic             presp_w  [NI];
  logic [LW-1:0]    mem_data;
  int               mem_lat;

  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    logic mresp;
    int   cnt;

    pmem_multi_arbiter #(
      .NUM_REQ  (NR),
      .ADDR_W   (AW),
      .LINE_W   (LW),
      .POLICY   ((gi == 1) ? 0 : 1),
      .COALESCE ((gi == 2) ? 0 : 1)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .req_read     (rd_v[gi]),
      .req_write    (wr_v[gi]),
      .req_addr     (addr_v[gi]),
      .req_wdata    (wdata_v[gi]),
      .req_rdata    (rdata_w[gi]),
      .req_resp     (resp_w[gi]),
      .grant_id     (gid_w[gi]),
      .busy         (busy_w[gi]),
      .pmem_read    (prd_w[gi]),
      .pmem_write   (pwr_w[gi]),
      .pmem_address (paddr_w[gi]),
      .pmem_wdata   (pwdata_w[gi]),
      .pmem_resp    (presp_w[gi]),
      .pmem_rdata   (mem_data)
    );

    // Memory responder: pmem_resp is high in the mem_lat-th strobe cycle
    always @(posedge clk) begin
      if (reset || !(prd_w[gi] || pwr_w[gi]) || mresp) begin
        cnt   <= 0;
        mresp <= 1'b0;
      end else if (cnt >= mem_lat - 2) begin
        mresp <= 1'b1;
      end else begin
        cnt <= cnt + 1;
      end
    end

    assign presp_w[gi] = mresp;
  end

  task automatic do_reset();
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      rd_v[k] = '0;
      wr_v[k] = '0;
      addr_v[k] = '0;
      wdata_v[k] = '0;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Waits (bounded) for any req_resp pulse on instance k, sampling at negedge
  task automatic wait_resp(input int k, input int budget, output logic [NR-1:0] vec,
                           output int cyc, output int mr, output int rdc, output int wrc,
                           output bit ok);
    vec = '0; cyc = 0; mr = 0; rdc = 0; wrc = 0; ok = 1'b0;
    while (cyc < budget && !ok) begin
      @(negedge clk);
      cyc++;
      if (presp_w[k]) mr++;
      if (prd_w[k]) rdc++;
      if (pwr_w[k]) wrc++;
      if (resp_w[k] != '0) begin
        vec = resp_w[k];
        ok = 1'b1;
      end
    end
    $display("txn inst=%0d resp=%b grant=%0d cycles=%0d pmem_resps=%0d", k, vec, gid_w[k], cyc, mr);
  endtask

  task automatic drop_all(input int k);
    @(posedge clk);
    #1;
    rd_v[k] = '0;
    wr_v[k] = '0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (busy_w[k] !== 1'b0 || prd_w[k] !== 1'b0 || pwr_w[k] !== 1'b0 || resp_w[k] !== '0) begin
        n_fail++;
        $display("FAIL reset_ctrl inst=%0d: busy=%b rd=%b wr=%b resp=%b, required all 0",
                 k, busy_w[k], prd_w[k], pwr_w[k], resp_w[k]);
      end
      n_checks++;
      if (gid_w[k] !== 2'd0 || paddr_w[k] !== '0 || rdata_w[k] !== '0 || pwdata_w[k] !== '0) begin
        n_fail++;
        $display("FAIL reset_regs inst=%0d: grant=%0d addr=%h, required 0", k, gid_w[k], paddr_w[k]);
      end
    end
  endtask

  task automatic test_single_read();
    logic [NR-1:0] vec;
    int cyc, mr, rdc, wrc;
    bit ok;
    logic [LW-1:0] exp_data;
    exp_data = {32{8'hA5}};
    do_reset();
    mem_lat = 3;
    mem_data = exp_data;
    addr_v[0][1*AW +: AW] = 32'h0000_1000;
    rd_v[0][1] = 1'b1;
    // Move into READ, then scramble the address to prove it was latched
    @(posedge clk);
    @(posedge clk);
    #1;
    addr_v[0][1*AW +: AW] = 32'hDEAD_BEEF;
    wait_resp(0, 20, vec, cyc, mr, rdc, wrc, ok);
    n_checks++;
    if (!ok || vec !== 3'b010) begin
      n_fail++;
      $display("FAIL rd_resp: ok=%0d resp=%b, required 010", ok, vec);
    end
    n_checks++;
    if (cyc !== 4 || rdc !== 3 || wrc !== 0 || mr !== 1) begin
      n_fail++;
      $display("FAIL rd_timing: cyc=%0d rd_cycles=%0d wr_cycles=%0d pmem_resps=%0d, required 4/3/0/1",
               cyc, rdc, wrc, mr);
    end
    n_checks++;
    if (paddr_w[0] !== 32'h0000_1000) begin
      n_fail++;
      $display("FAIL rd_addr: got %h required 00001000", paddr_w[0]);
    end
    n_checks++;
    if (rdata_w[0] !== exp_data) begin
      n_fail++;
      $display("FAIL rd_data: got %h required %h", rdata_w[0], exp_data);
    end
    drop_all(0);
    @(negedge clk);
    n_checks++;
    if (resp_w[0] !== '0) begin
      n_fail++;
      $display("FAIL rd_pulse_width: resp=%b one cycle after, required 000", resp_w[0]);
    end
    mem_data = '0;
    @(negedge clk);
    n_checks++;
    if (rdata_w[0] !== exp_data) begin
      n_fail++;
      $display("FAIL rd_data_hold: got %h required %h", rdata_w[0], exp_data);
    end
  endtask

  task automatic test_write();
    logic [NR-1:0] vec;
    int cyc, mr, rdc, wrc;
    bit ok;
    do_reset();
    mem_lat = 3;
    addr_v[0][0 +: AW] = 32'h0000_2040;
    wdata_v[0][0 +: LW] = 256'h1234;
    wr_v[0][0] = 1'b1;
    wait_resp(0, 20, vec, cyc, mr, rdc, wrc, ok);
    n_checks++;
    if (!ok || vec !== 3'b001) begin
      n_fail++;
      $display("FAIL wr_resp: ok=%0d resp=%b, required 001", ok, vec);
    end
    n_checks++;
    if (cyc !== 6 || wrc !== 3 || rdc !== 0 || mr !== 1) begin
      n_fail++;
      $display("FAIL wr_timing: cyc=%0d wr_cycles=%0d rd_cycles=%0d pmem_resps=%0d, required 6/3/0/1",
               cyc, wrc, rdc, mr);
    end
    n_checks++;
    if (pwdata_w[0] !== 256'h1234 || paddr_w[0] !== 32'h0000_2040) begin
      n_fail++;
      $display("FAIL wr_regs: wdata=%h addr=%h, required 1234 / 00002040", pwdata_w[0], paddr_w[0]);
    end
    drop_all(0);
  endtask

  task automatic test_fixed_priority();
    logic [NR-1:0] vec;
    int cyc, mr, rdc, wrc;
    bit ok;
    do_reset();
    mem_lat = 2;
    for (int i = 0; i < NR; i++) begin
      addr_v[1][i*AW +: AW] = 32'h0000_5000 + 32'(i) * 32'h40;
    end
    rd_v[1] = 3'b111;
    for (int n = 0; n < 4; n++) begin
      wait_resp(1, 20, vec, cyc, mr, rdc, wrc, ok);
      n_checks++;
      if (!ok || vec !== 3'b001 || gid_w[1] !== 2'd0) begin
        n_fail++;
        $display("FAIL fixed_order[%0d]: resp=%b grant=%0d, required 001 / 0", n, vec, gid_w[1]);
      end
    end
    drop_all(1);
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] vec;
    logic [NR-1:0] exp_vec [4];
    int cyc, mr, rdc, wrc;
    bit ok;
    exp_vec[0] = 3'b001; exp_vec[1] = 3'b010; exp_vec[2] = 3'b100; exp_vec[3] = 3'b001;
    do_reset();
    mem_lat = 2;
    for (int i = 0; i < NR; i++) begin
      addr_v[0][i*AW +: AW] = 32'h0000_6000 + 32'(i) * 32'h40;
    end
    rd_v[0] = 3'b111;
    for (int n = 0; n < 4; n++) begin
      wait_resp(0, 20, vec, cyc, mr, rdc, wrc, ok);
      n_checks++;
      if (!ok || vec !== exp_vec[n]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: resp=%b, required %b", n, vec, exp_vec[n]);
      end
    end
    drop_all(0);
  endtask

  task automatic test_coalesce();
    logic [NR-1:0] vec;
    int cyc, mr, rdc, wrc, total;
    bit ok;
    // Coalescing instance: one pmem read answers both requesters
    do_reset();
    mem_lat = 2;
    mem_data = {8{32'h3000_0BAD}};
    addr_v[0][0*AW +: AW] = 32'h0000_3000;
    addr_v[0][2*AW +: AW] = 32'h0000_3000;
    rd_v[0] = 3'b101;
    wait_resp(0, 20, vec, cyc, mr, rdc, wrc, ok);
    n_checks++;
    if (!ok || vec !== 3'b101 || mr !== 1) begin
      n_fail++;
      $display("FAIL coal_on: resp=%b pmem_resps=%0d, required 101 / 1", vec, mr);
    end
    drop_all(0);
    wait_resp(0, 8, vec, cyc, mr, rdc, wrc, ok);
    n_checks++;
    if (ok || mr !== 0) begin
      n_fail++;
      $display("FAIL coal_extra: resp=%b pmem_resps=%0d, required no further transaction", vec, mr);
    end
    // Non-coalescing instance: two separate transactions
    do_reset();
    addr_v[2][0*AW +: AW] = 32'h0000_3000;
    addr_v[2][2*AW +: AW] = 32'h0000_3000;
    rd_v[2] = 3'b101;
    wait_resp(2, 20, vec, cyc, mr, rdc, wrc, ok);
    total = mr;
    n_checks++;
    if (!ok || vec !== 3'b001) begin
      n_fail++;
      $display("FAIL coal_off_first: resp=%b, required 001", vec);
    end
    @(posedge clk);
    #1;
    rd_v[2][0] = 1'b0;
    wait_resp(2, 20, vec, cyc, mr, rdc, wrc, ok);
    total += mr;
    n_checks++;
    if (!ok || vec !== 3'b100 || gid_w[2] !== 2'd2 || total !== 2) begin
      n_fail++;
      $display("FAIL coal_off_second: resp=%b grant=%0d pmem_resps=%0d, required 100 / 2 / 2",
               vec, gid_w[2], total);
    end
    drop_all(2);
  endtask

  task automatic test_reset_mid_read();
    logic [NR-1:0] vec;
    int cyc, mr, rdc, wrc;
    bit ok;
    bit seen;
    do_reset();
    mem_lat = 10;
    mem_data = {8{32'hCAFE_F00D}};
    addr_v[0][1*AW +: AW] = 32'h0000_4000;
    rd_v[0][1] = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (prd_w[0]) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL mid_strobe: pmem_read=%b after 10 cycles, required 1", prd_w[0]);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy_w[0] !== 1'b0 || prd_w[0] !== 1'b0 || resp_w[0] !== '0 || rdata_w[0] !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b rd=%b resp=%b rdata=%h, required 0/0/000/0",
               busy_w[0], prd_w[0], resp_w[0], rdata_w[0]);
    end
    mem_lat = 2;
    reset = 1'b0;
    wait_resp(0, 20, vec, cyc, mr, rdc, wrc, ok);
    n_checks++;
    if (!ok || vec !== 3'b010 || rdata_w[0] !== {8{32'hCAFE_F00D}}) begin
      n_fail++;
      $display("FAIL mid_recover: resp=%b rdata=%h, required 010 / cafef00d..", vec, rdata_w[0]);
    end
    drop_all(0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    mem_lat = 3;
    mem_data = '0;
    reset = 1'b1;
    test_reset();
    test_single_read();
    test_write();
    test_fixed_priority();
    test_round_robin();
    test_coalesce();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
